gesture_ascii_framer: RTL

//  Sits between i2c_controller and Uart_Transmission in the Paj7620 design.

---
 rtl/gesture_ascii_framer_pkg.sv | 16 +
 rtl/gesture_fifo.sv | 42 ++++
 rtl/gesture_ascii_framer.sv | 100 ++++++++++
 3 files changed

// File: rtl/gesture_ascii_framer_pkg.sv
// gesture_ascii_framer_pkg: FSM states, ASCII constants and gesture-to-mnemonic encoder
package gesture_ascii_framer_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GUARD, ST_WAIT} state_t;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  // Two-character mnemonics packed bit 7 down to bit 0, char0 in the upper byte of each entry
  localparam logic [127:0] MNEM_TABLE = {"AC", "CW", "BK", "FW", "RT", "LT", "DN", "UP"};
  localparam logic [15:0] MNEM_MIX = "MX";
  function automatic logic [15:0] mnemonic(input logic [7:0] w);
    logic [15:0] m;
    m = MNEM_MIX;
    for (int i = 0; i < 8; i++)
      if ($onehot(w) && w[i]) m = MNEM_TABLE[i*16 +: 16];
    return m;
  endfunction
endpackage

// File: rtl/gesture_fifo.sv
// gesture_fifo: synchronous FIFO of gesture words
// Ports: Clk_i/Reset_i (sync, active-high); i_push/i_data write side; i_pop/o_data read side
//        (o_data is the head word, valid while not empty); o_full; o_count (occupancy).
module gesture_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              i_push,
  input  logic [7:0]        i_data,
  input  logic              i_pop,
  output logic [7:0]        o_data,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count
);
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr;
  logic [ADDR_W-1:0] r_rd;
  logic [ADDR_W:0]   r_count;
  logic              w_pop;
  logic              w_push;
  assign o_full  = r_count == (ADDR_W+1)'(DEPTH);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && r_count != '0;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign w_push  = i_push && (!o_full || w_pop);
  always_ff @(posedge Clk_i)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
    end
  end
endmodule

// File: rtl/gesture_ascii_framer.sv
// gesture_ascii_framer: buffers PAJ7620 gesture words and sends each as an ASCII record to a UART
// Ports: Clk_i, Reset_i (sync, active-high); Gesture_i/Data_Available_i capture side;
//        Uart_Busy_i, Byte_o, Byte_Valid_o UART side; Overflow_o sticky drop flag; Fifo_Empty_o.
module gesture_ascii_framer
  import gesture_ascii_framer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2,
  parameter bit SEND_CRLF  = 1'b1
) (
  input  logic       Clk_i,
  input  logic       Reset_i,
  input  logic [7:0] Gesture_i,
  input  logic       Data_Available_i,
  input  logic       Uart_Busy_i,
  output logic [7:0] Byte_o,
  output logic       Byte_Valid_o,
  output logic       Overflow_o,
  output logic       Fifo_Empty_o
);
  localparam logic [1:0] LAST = SEND_CRLF ? 2'd3 : 2'd1;
  state_t          r_state;
  state_t          w_next;
  logic            r_push;
  logic [7:0]      r_push_data;
  logic [7:0]      r_word;
  logic [7:0]      r_rec [4];
  logic [1:0]      r_idx;
  logic [7:0]      r_byte;
  logic            r_ovf;
  logic            w_pop;
  logic            w_send;
  logic            w_full;
  logic [7:0]      w_head;
  logic [ADDR_W:0] w_count;
  logic [15:0]     w_mnem;
  gesture_fifo #(.DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_count (w_count)
  );
  assign Fifo_Empty_o = w_count == '0;
  assign w_mnem       = mnemonic(r_word);
  assign Byte_Valid_o = w_send;
  // Byte_o shows the new byte in its strobe cycle, then holds it from r_byte
  assign Byte_o       = w_send ? r_rec[r_idx] : r_byte;
  assign Overflow_o   = r_ovf;
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_send = 1'b0;
    case (r_state)
      ST_IDLE: if (!Fifo_Empty_o) begin
        w_pop  = 1'b1;
        w_next = ST_LOAD;
      end
      ST_LOAD: w_next = ST_SEND;
      ST_SEND: if (!Uart_Busy_i) begin
        w_send = 1'b1;
        w_next = ST_GUARD;
      end
      // The UART raises busy only the cycle after the strobe, so one cycle is skipped here
      ST_GUARD: w_next = ST_WAIT;
      ST_WAIT: if (!Uart_Busy_i) w_next = r_idx == LAST ? ST_IDLE : ST_SEND;
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      r_state     <= ST_IDLE;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_word      <= '0;
      r_idx       <= '0;
      r_byte      <= '0;
      r_ovf       <= 1'b0;
      for (int i = 0; i < 4; i++) r_rec[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_push      <= Data_Available_i && Gesture_i != '0;
      r_push_data <= Gesture_i;
      if (w_pop) r_word <= w_head;
      if (r_state == ST_LOAD) begin
        r_rec[0] <= w_mnem[15:8];
        r_rec[1] <= w_mnem[7:0];
        r_rec[2] <= ASCII_CR;
        r_rec[3] <= ASCII_LF;
        r_idx    <= '0;
      end
      if (w_send) r_byte <= r_rec[r_idx];
      if (r_state == ST_WAIT && !Uart_Busy_i && r_idx != LAST) r_idx <= r_idx + 1'b1;
      if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end
endmodule
